// File: rtl/ray_dir_recip_iter_pkg.sv
// Shared types and default number formats for the ray-direction reciprocal unit.
// Optional saturation build: RAY_INV_SAT_EN (see ray_dir_recip_iter_recip_lane).
package ray_dir_recip_iter_pkg;

    localparam int DEF_LANES    = 3;
    localparam int DEF_IN_W     = 32;
    localparam int DEF_IN_FRAC  = 16;
    localparam int DEF_OUT_W    = 36;
    localparam int DEF_OUT_FRAC = 18;

    typedef logic [DEF_LANES-1:0][DEF_IN_W-1:0]  vec3;
    typedef logic [DEF_LANES-1:0][DEF_OUT_W-1:0] vec3_18_18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One quotient bit per divide cycle: integer part plus both fraction fields.
    function automatic int iter_bits(input int in_frac, input int out_frac);
        return in_frac + out_frac + 1;
    endfunction

endpackage

// File: rtl/ray_dir_recip_iter_if.sv
// Input/output vector handshake bundle for ray_dir_recip_iter.
interface ray_dir_recip_iter_if #(
    parameter int LANES = 3,
    parameter int IN_W  = 32,
    parameter int OUT_W = 36
);
    // Valid/ready: a beat transfers on a rising edge where valid && ready. The
    // source holds valid and its payload until the transfer; ready may depend on
    // the opposite side's valid within the same cycle.
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_dir;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_inv;
    logic [LANES-1:0]       out_dbz;
    logic [LANES-1:0]       out_ovf;

    modport master (
        output in_valid, in_dir, out_ready,
        input  in_ready, out_valid, out_inv, out_dbz, out_ovf
    );

    modport slave (
        input  in_valid, in_dir, out_ready,
        output in_ready, out_valid, out_inv, out_dbz, out_ovf
    );
endinterface

// File: rtl/ray_dir_recip_iter_recip_lane.sv
// One lane of the reciprocal: |d| capture, restoring shift-subtract, sign/saturation finish.
// RAY_INV_SAT_EN selects saturating results for zero/overflowing lanes; otherwise 0 / wrap.
module ray_dir_recip_iter_recip_lane
    import ray_dir_recip_iter_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int ITER  = iter_bits(DEF_IN_FRAC, DEF_OUT_FRAC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             shift_bit_i,
    input  logic             finish_i,
    input  logic [IN_W-1:0]  d_i,
    output logic [OUT_W-1:0] inv_o,
    output logic             dbz_o,
    output logic             ovf_o
);

    localparam int QW = ((ITER > OUT_W) ? ITER : OUT_W) + 1;
    localparam logic [QW-1:0] LIM = QW'(1) << (OUT_W - 1);
`ifdef RAY_INV_SAT_EN
    localparam logic [OUT_W-1:0] MAXP = {1'b0, {(OUT_W-1){1'b1}}};
`endif

    logic              sign_q, sign_d;
    logic              zero_q, zero_d;
    logic [IN_W-1:0]   mag_q, mag_d;
    logic [IN_W-1:0]   rem_q, rem_d;
    logic [ITER-1:0]   quo_q, quo_d;
    logic [OUT_W-1:0]  inv_q, inv_d;
    logic              dbz_q, dbz_d;
    logic              ovf_q, ovf_d;

    logic [IN_W:0]     rem_sh;
    logic [IN_W:0]     rem_sub;
    logic [QW-1:0]     q_ext;
    logic [OUT_W-1:0]  q_lo;
    logic [OUT_W-1:0]  res_lo;
    logic              ovf_w;

    always_comb begin
        sign_d = sign_q;
        zero_d = zero_q;
        mag_d  = mag_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        inv_d  = inv_q;
        dbz_d  = dbz_q;
        ovf_d  = ovf_q;

        // The remainder stays below |d| <= 2^(IN_W-1), so IN_W bits hold it
        // and one extra bit holds the shifted trial value.
        rem_sh  = {rem_q, shift_bit_i};
        rem_sub = rem_sh - {1'b0, mag_q};
        q_ext   = QW'(quo_q);
        q_lo    = OUT_W'(quo_q);
        res_lo  = sign_q ? (~q_lo + 1'b1) : q_lo;
        ovf_w   = !zero_q && (q_ext >= LIM);

        if (load_i) begin
            sign_d = d_i[IN_W-1];
            mag_d  = d_i[IN_W-1] ? (~d_i + 1'b1) : d_i;
            zero_d = (d_i == '0);
            rem_d  = '0;
            quo_d  = '0;
        end else if (step_i) begin
            if (rem_sh >= {1'b0, mag_q}) begin
                rem_d = rem_sub[IN_W-1:0];
                quo_d = {quo_q[ITER-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[IN_W-1:0];
                quo_d = {quo_q[ITER-2:0], 1'b0};
            end
        end else if (finish_i) begin
            dbz_d = zero_q;
            ovf_d = ovf_w;
`ifdef RAY_INV_SAT_EN
            if (zero_q) begin
                inv_d = MAXP;
            end else if (ovf_w) begin
                inv_d = sign_q ? (~MAXP + 1'b1) : MAXP;
            end else begin
                inv_d = res_lo;
            end
`else
            inv_d = zero_q ? '0 : res_lo;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            mag_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            inv_q  <= '0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sign_q <= sign_d;
            zero_q <= zero_d;
            mag_q  <= mag_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            inv_q  <= inv_d;
            dbz_q  <= dbz_d;
            ovf_q  <= ovf_d;
        end
    end

    assign inv_o = inv_q;
    assign dbz_o = dbz_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/ray_dir_recip_iter.sv
// Multi-lane iterative fixed-point reciprocal (1/d) for ray inverse directions.
// Optional build macro: RAY_INV_SAT_EN (saturate zero/overflowing lanes).
module ray_dir_recip_iter
    import ray_dir_recip_iter_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int IN_W     = DEF_IN_W,
    parameter int IN_FRAC  = DEF_IN_FRAC,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int OUT_FRAC = DEF_OUT_FRAC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ray_dir_recip_iter_if.slave  bus,
    output state_t               dbg_state
);

    localparam int ITER = iter_bits(IN_FRAC, OUT_FRAC);
    localparam int CW   = $clog2(ITER + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready;
    logic            accept;
    logic            step;
    logic            finish;
    logic            shift_bit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step      = 1'b0;
        finish    = 1'b0;
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        accept    = bus.in_valid && in_ready;
        // Dividend is 2^(ITER-1): its only set bit enters on the first step.
        shift_bit = (cnt_q == CW'(ITER));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DIV;
                    cnt_d   = CW'(ITER);
                end
            end
            DIV: begin
                if (cnt_q != '0) begin
                    step  = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = DIV;
                    cnt_d   = CW'(ITER);
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign dbg_state     = state_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ray_dir_recip_iter_recip_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .ITER  (ITER)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (accept),
            .step_i      (step),
            .shift_bit_i (shift_bit),
            .finish_i    (finish),
            .d_i         (bus.in_dir[i*IN_W +: IN_W]),
            .inv_o       (bus.out_inv[i*OUT_W +: OUT_W]),
            .dbz_o       (bus.out_dbz[i]),
            .ovf_o       (bus.out_ovf[i])
        );
    end

endmodule

// File: tb/tb_ray_dir_recip_iter.sv
// Bench for ray_dir_recip_iter: default instance plus an OUT_W=30 instance driven in lockstep,
// both scored against an arithmetic reciprocal model (honours RAY_INV_SAT_EN).
module tb_ray_dir_recip_iter;
    import ray_dir_recip_iter_pkg::*;

    localparam int ITER  = 35;
    localparam int OW_A  = 36;
    localparam int OW_B  = 30;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic [95:0] in_dir   = '0;
    logic        out_ready = 1'b0;

    ray_dir_recip_iter_if #(.LANES(3), .IN_W(32), .OUT_W(OW_A)) bus_a ();
    ray_dir_recip_iter_if #(.LANES(3), .IN_W(32), .OUT_W(OW_B)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_dir    = in_dir;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_dir    = in_dir;
    assign bus_b.out_ready = out_ready;

    state_t dbg_a, dbg_b;

    ray_dir_recip_iter dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_a.slave),
        .dbg_state (dbg_a)
    );

    ray_dir_recip_iter #(.OUT_W(OW_B)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_b.slave),
        .dbg_state (dbg_b)
    );

    // ---------------- scoreboard ----------------
    logic [65:0] exp_a_q[$];
    logic [65:0] exp_b_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: floor(2^34 / |d|), sign applied, then saturate or wrap to ow bits.
    function automatic logic [65:0] ref_lane(input logic signed [31:0] d, input int ow);
        longint q, res, maxp, mask, mag;
        logic dbz, ovf;
        logic [63:0] v;
        mask = (longint'(1) <<< ow) - 1;
        maxp = (longint'(1) <<< (ow - 1)) - 1;
        dbz  = (d == 0);
        ovf  = 1'b0;
        if (dbz) begin
`ifdef RAY_INV_SAT_EN
            v = 64'(maxp);
`else
            v = 64'd0;
`endif
        end else begin
            mag = (d < 0) ? -longint'(d) : longint'(d);
            q   = (longint'(1) <<< 34) / mag;
            ovf = (q > maxp);
            res = (d < 0) ? -q : q;
`ifdef RAY_INV_SAT_EN
            if (ovf) res = (d < 0) ? -maxp : maxp;
`endif
            v = 64'(res & mask);
        end
        return {dbz, ovf, v};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_expect(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        logic [31:0] d [3];
        d[0] = x; d[1] = y; d[2] = z;
        for (int i = 0; i < 3; i++) begin
            exp_a_q.push_back(ref_lane(d[i], OW_A));
            exp_b_q.push_back(ref_lane(d[i], OW_B));
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        @(negedge clk);
        check_val("in_ready_idle", 64'(bus_a.in_ready), 64'd1);
        in_valid  = 1'b1;
        in_dir    = {z, y, x};
        out_ready = 1'b0;
        push_expect(x, y, z);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_dir   = {$urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus_a.out_valid && cyc < 200);
        check_val({tag, "_latency"}, 64'(cyc), 64'(ITER + 1));
        check_val({tag, "_b_valid"}, 64'(bus_b.out_valid), 64'd1);
    endtask

    task automatic check_result(input string tag);
        logic [65:0] e;
        for (int i = 0; i < 3; i++) begin
            e = exp_a_q.pop_front();
            check_val($sformatf("%s_a_inv%0d", tag, i), 64'(bus_a.out_inv[i*OW_A +: OW_A]), e[63:0]);
            check_val($sformatf("%s_a_dbz%0d", tag, i), 64'(bus_a.out_dbz[i]), 64'(e[65]));
            check_val($sformatf("%s_a_ovf%0d", tag, i), 64'(bus_a.out_ovf[i]), 64'(e[64]));
            e = exp_b_q.pop_front();
            check_val($sformatf("%s_b_inv%0d", tag, i), 64'(bus_b.out_inv[i*OW_B +: OW_B]), e[63:0]);
            check_val($sformatf("%s_b_dbz%0d", tag, i), 64'(bus_b.out_dbz[i]), 64'(e[65]));
            check_val($sformatf("%s_b_ovf%0d", tag, i), 64'(bus_b.out_ovf[i]), 64'(e[64]));
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_valid_drop"}, 64'(bus_a.out_valid), 64'd0);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z);
        send(x, y, z);
        wait_out(tag);
        check_result(tag);
        release_out(tag);
    endtask

    function automatic logic [31:0] rand_dir();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 16));
            2:       return 32'h8000_0000;
            3:       return $urandom;
            4:       return 32'(-int'($urandom_range(1, 1 << 20)));
            default: return 32'($urandom_range(1, 1 << 20));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int vcount;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(bus_a.out_valid), 64'd0);
        check_val("rst_inv", 64'(|bus_a.out_inv), 64'd0);
        check_val("rst_flags", 64'({bus_a.out_dbz, bus_a.out_ovf}), 64'd0);
        check_val("rst_state", 64'(dbg_a), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("idle_in_ready", 64'(bus_a.in_ready), 64'd1);

        run_vec("t1", 32'd8192, 32'd2048, 32'd0);
        run_vec("t2", 32'hFFFF_0000, 32'd196608, 32'd1);
        run_vec("t3", 32'd1, 32'h8000_0000, 32'hFFFF_FFFF);

        // Backpressure, then accept in the same cycle the result leaves.
        send(32'd12345, 32'hFFFE_0000, 32'd7);
        wait_out("t4");
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check_val("bp_valid", 64'(bus_a.out_valid), 64'd1);
            check_val("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
        end
        check_result("t4_hold");
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_dir    = {32'd300000, 32'hFFFF_FFF0, 32'd65536};
        push_expect(32'd65536, 32'hFFFF_FFF0, 32'd300000);
        #1;
        check_val("b2b_in_ready", 64'(bus_a.in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_dir    = {$urandom, $urandom, $urandom};
        check_val("b2b_valid_drop", 64'(bus_a.out_valid), 64'd0);
        wait_out("t4b");
        check_result("t4b");
        release_out("t4b");

        // Reset in the middle of a divide discards the operation.
        send(32'd4096, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
        check_val("mid_rst_inv", 64'(|bus_a.out_inv), 64'd0);
        check_val("mid_rst_flags", 64'({bus_a.out_dbz, bus_a.out_ovf}), 64'd0);
        check_val("mid_rst_state", 64'(dbg_a), 64'(IDLE));
        exp_a_q.delete();
        exp_b_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (bus_a.out_valid || bus_b.out_valid) vcount++;
        end
        check_val("post_rst_no_valid", 64'(vcount), 64'd0);
        run_vec("t5", 32'd98304, 32'hFFFF_8000, 32'd0);

        for (int n = 0; n < 12; n++) begin
            run_vec($sformatf("rnd%0d", n), rand_dir(), rand_dir(), rand_dir());
        end

        check_val("scoreboard_empty", 64'(exp_a_q.size() + exp_b_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
